plc_input_stage: RTL and testbench
==================================

# plc_input_stage

PLC input stage, directly upstream of the `up` processor core. It synchronises and debounces the raw digital input pins (start/stop buttons, status lines) and latches their rising edges. It also snapshots and moving-average filters the 16-bit analog pressure word. All results are exposed to the core through a small registered read port with a one-cycle acknowledge.

## Interface
- `DEBOUNCE_CYCLES`, 4: number of consecutive differing synchronised samples required to accept a new digital level (≥2)
- `AVG_SHIFT`, 2: log2 of the analog moving-average window (window = 2^AVG_SHIFT samples, 0..4)
- `NDIN`, 4: number of digital input pins (1..16)

Ports:
- `clk_in`  input  1  system clock; all logic on rising edge
- `rst_in`  input  1  asynchronous, active-low reset
- `din_in`  input  NDIN  raw asynchronous digital pins
- `ain_in`  input  16  raw analog word (unsigned)
- `sample_en_in`  input  1  analog sample strobe (PLC scan tick), one-cycle pulse
- `rd_req_in`  input  1  read request from core
- `rd_addr_in`  input  2  register select
- `rd_data_out`  output  16  read data, registered
- `rd_ack_out`  output  1  read acknowledge, one-cycle pulse

## Operation
- Reset (rst_in low, asynchronous): sync flops, debounced state, counters, edge latches, analog history, accumulator, snapshot, `rd_data_out` and `rd_ack_out` all 0.
- Digital path, per bit i:
  - Two-flop synchroniser feeds `sync2[i]`.
  - Each edge where `sync2[i] == stable[i]`: `cnt[i] <= 0`.
  - Each edge where they differ:
    - If `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= sync2[i]` and `cnt[i] <= 0`.
    - Otherwise: `cnt[i]++`.
  - Glitches shorter than `DEBOUNCE_CYCLES` synchronised samples are rejected; any agreeing sample restarts the count.
- Edge latch: `edge[i]` sets on the same edge that `stable[i]` goes 0→1. It stays set until a read of address 1.
- Analog path, on each edge with `sample_en_in` high:
  - `raw <= ain_in`.
  - Shift `ain_in` into a 2^AVG_SHIFT-deep history.
  - `sum <= sum + ain_in - oldest`.
  - `sum` is 16+AVG_SHIFT bits wide, so it never overflows.
  - `avg = sum >> AVG_SHIFT`, floor, taken from the registered `sum`.
  - With no strobe, everything holds.
- Register map, zero-extended to 16 bits:
  - Address 0: `stable`.
  - Address 1: `edge` (clear-on-read).
  - Address 2: `avg`.
  - Address 3: `raw`.
- Read: on an edge with `rd_req_in` high, `rd_data_out <= reg[rd_addr_in]` and `rd_ack_out <= 1`. Otherwise `rd_ack_out <= 0` and `rd_data_out` holds its last value.
- Clear-on-read, address 1:
  - Edge bits are cleared on the capturing edge.
  - If a new rising edge sets bit i on that same edge, the set wins. The bit remains 1 and is returned by the next read.
- Back-to-back requests are allowed; each produces its own ack.

## Timing
- Digital latency, for a pin change meeting setup before edge k:
  - Sampled by sync1 at edge k; `sync2` at k+1.
  - `stable` and `edge` update at edge k+1+DEBOUNCE_CYCLES (k+5 with the default).
  - Visible in a read requested at that edge+1.
- Read latency: `rd_ack_out` and `rd_data_out` are valid in the cycle after the request edge, for exactly one cycle per request.
- Analog: `raw` and `avg` reflect a strobe at edge s from edge s onward. A read requested on edge s returns the pre-strobe values.
- Reset mid-operation: all debounce and filter progress is lost.
  - A pin held high through reset release is re-acquired after full latency, and its edge bit sets again.
  - If `rd_req_in` is high on the first edge after release, it is served normally.
- Simultaneous `sample_en_in` and `rd_req_in` (address 2/3): the read returns the old value.

## Test plan
- Reset, then read addresses 0–3 -> every read acks one cycle later with data 0x0000; `rd_ack_out` is 0 when idle.
- Raise `din_in[0]` before edge k, hold -> `stable[0]` = 1 at edge k+5. Read address 1 -> 0x0001. Second read of address 1 -> 0x0000. Read address 0 -> 0x0001.
- Pulse `din_in[1]` high for 3 cycles, then low -> `stable` never changes and address 1 reads 0x0000. A 6-cycle pulse sets bit 1 (reads 0x0002).
- `ain_in` = 0xBFFF, one strobe -> address 2 = 0x2FFF, address 3 = 0xBFFF. After 4 strobes -> address 2 = 0xBFFF. Then `ain_in` = 0x0000 for 4 strobes -> address 2 = 0x0000.
- Address 1 read request issued on the same edge that `stable[0]` rises -> that read returns 0x0000 and the next read returns 0x0001.
- Assert `rst_in` low mid-debounce with `din_in[0]` high, release -> `stable[0]` rises DEBOUNCE_CYCLES+2 edges after release, and `edge[0]` sets.

Source files
------------

// File: rtl/plc_input_stage_if.sv
// Read port between the PLC input stage and the processor core.
// The core drives request/address; the input stage returns registered data and a one-cycle ack.
interface plc_input_stage_if;
    logic        rd_req_in;
    logic [1:0]  rd_addr_in;
    logic [15:0] rd_data_out;
    logic        rd_ack_out;

    modport master (output rd_req_in, output rd_addr_in, input rd_data_out, input rd_ack_out);
    modport slave  (input rd_req_in, input rd_addr_in, output rd_data_out, output rd_ack_out);
endinterface

// File: rtl/plc_input_stage.sv
// PLC input stage: synchronises/debounces digital pins, latches rising edges,
// moving-average filters the analog word and serves a small registered read port.
module plc_input_stage #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AVG_SHIFT       = 2,
    parameter int NDIN            = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [NDIN-1:0]  din_in,
    input  logic [15:0]      ain_in,
    input  logic             sample_en_in,
    plc_input_stage_if.slave rd
);
    localparam int CW    = $clog2(DEBOUNCE_CYCLES);
    localparam int DEPTH = 1 << AVG_SHIFT;
    localparam int SW    = 16 + AVG_SHIFT;

    logic [NDIN-1:0]          sync1_r;
    logic [NDIN-1:0]          sync2_r;
    logic [NDIN-1:0]          stable_r;
    logic [NDIN-1:0]          edge_r;
    logic [NDIN-1:0][CW-1:0]  cnt_r;
    logic [DEPTH-1:0][15:0]   hist_r;
    logic [SW-1:0]            sum_r;
    logic [15:0]              raw_r;
    logic [15:0]              rd_data_r;
    logic                     rd_ack_r;

    logic [NDIN-1:0]          stable_nxt_s;
    logic [NDIN-1:0]          edge_nxt_s;
    logic [NDIN-1:0]          rise_s;
    logic [NDIN-1:0][CW-1:0]  cnt_nxt_s;
    logic [SW-1:0]            sum_nxt_s;
    logic [15:0]              rd_mux_s;

    // Debounce: any agreeing sample restarts the count; DEBOUNCE_CYCLES differing samples accept the new level
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        rise_s       = {NDIN{1'b0}};
        for (int i = 0; i < NDIN; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = {CW{1'b0}};
                rise_s[i]       = sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

    // Edge latches: a read of address 1 clears them, but a rise on the same edge wins
    always_comb begin
        if (rd.rd_req_in && (rd.rd_addr_in == 2'd1)) begin
            edge_nxt_s = rise_s;
        end else begin
            edge_nxt_s = edge_r | rise_s;
        end
    end

    // Running sum: the intermediate may wrap, the SW-bit result is always exact
    always_comb begin
        sum_nxt_s = sum_r + SW'(ain_in) - SW'(hist_r[DEPTH-1]);
    end

    // Register map, all fields zero-extended to 16 bits
    always_comb begin
        case (rd.rd_addr_in)
            2'd0:    rd_mux_s = 16'(stable_r);
            2'd1:    rd_mux_s = 16'(edge_r);
            2'd2:    rd_mux_s = 16'(sum_r >> AVG_SHIFT);
            2'd3:    rd_mux_s = raw_r;
            default: rd_mux_s = 16'h0000;
        endcase
    end

    // Digital path state: synchroniser, debounce counters, stable level and edge latches
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_r  <= {NDIN{1'b0}};
            sync2_r  <= {NDIN{1'b0}};
            stable_r <= {NDIN{1'b0}};
            edge_r   <= {NDIN{1'b0}};
            cnt_r    <= '0;
        end else begin
            sync1_r  <= din_in;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            edge_r   <= edge_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Analog path state: snapshot, sample history and running sum advance only on a strobe
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hist_r <= '0;
            sum_r  <= {SW{1'b0}};
            raw_r  <= 16'h0000;
        end else if (sample_en_in) begin
            hist_r[0] <= ain_in;
            for (int i = 1; i < DEPTH; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
            sum_r <= sum_nxt_s;
            raw_r <= ain_in;
        end else begin
            hist_r <= hist_r;
            sum_r  <= sum_r;
            raw_r  <= raw_r;
        end
    end

    // Read port: data captured from pre-edge register values, ack pulses once per request
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_data_r <= 16'h0000;
            rd_ack_r  <= 1'b0;
        end else if (rd.rd_req_in) begin
            rd_data_r <= rd_mux_s;
            rd_ack_r  <= 1'b1;
        end else begin
            rd_data_r <= rd_data_r;
            rd_ack_r  <= 1'b0;
        end
    end

    assign rd.rd_data_out = rd_data_r;
    assign rd.rd_ack_out  = rd_ack_r;
endmodule

// File: tb/tb_plc_input_stage.sv
// Randomised and directed bench for plc_input_stage with a queue-based scoreboard
// fed by a behavioural model of the pins, debounce runs and analog window.
module tb_plc_input_stage;
    localparam int D     = 4;
    localparam int AS    = 2;
    localparam int NDIN  = 4;
    localparam int WIN   = 1 << AS;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [NDIN-1:0]  din_in;
    logic [15:0]      ain_in;
    logic             sample_en_in;

    plc_input_stage_if rd ();

    plc_input_stage #(.DEBOUNCE_CYCLES(D), .AVG_SHIFT(AS), .NDIN(NDIN)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .din_in       (din_in),
        .ain_in       (ain_in),
        .sample_en_in (sample_en_in),
        .rd           (rd.slave)
    );

    always #5 clk_in = ~clk_in;

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] sbq[$];

    // ---------------- behavioural reference model ----------------
    bit          m_pin_d1[NDIN];
    bit          m_pin_d2[NDIN];
    bit          m_level[NDIN];
    int          m_run[NDIN];
    bit          m_edge[NDIN];
    int          m_samples[$];
    int          m_raw;

    function automatic logic [15:0] pack_bits(input bit b[NDIN]);
        int v = 0;
        for (int i = 0; i < NDIN; i++) if (b[i]) v += (1 << i);
        return 16'(v);
    endfunction

    function automatic logic [15:0] model_read(input int addr);
        int total = 0;
        foreach (m_samples[j]) total += m_samples[j];
        case (addr)
            0: return pack_bits(m_level);
            1: return pack_bits(m_edge);
            2: return 16'(total / WIN);
            default: return 16'(m_raw);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIN; i++) begin
            m_pin_d1[i] = 0; m_pin_d2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_edge[i] = 0;
        end
        m_samples.delete();
        for (int j = 0; j < WIN; j++) m_samples.push_back(0);
        m_raw = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            if (!rst_in) begin
                model_reset();
            end else begin
                if (rd.rd_req_in) begin
                    sbq.push_back(model_read(int'(rd.rd_addr_in)));
                    if (rd.rd_addr_in == 2'd1)
                        for (int i = 0; i < NDIN; i++) m_edge[i] = 0;
                end
                for (int i = 0; i < NDIN; i++) begin
                    // a new level is believed after D consecutive samples that disagree with it
                    if (m_pin_d2[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == D) begin
                            m_level[i] = m_pin_d2[i];
                            m_run[i]   = 0;
                            if (m_level[i]) m_edge[i] = 1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    m_pin_d2[i] = m_pin_d1[i];
                    m_pin_d1[i] = din_in[i];
                end
                if (sample_en_in) begin
                    m_samples.push_front(int'(ain_in));
                    void'(m_samples.pop_back());
                    m_raw = int'(ain_in);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [15:0] exp_d;
        logic        exp_ack;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                exp_ack = (sbq.size() != 0);
                compared++;
                if (rd.rd_ack_out !== exp_ack) begin
                    mismatched++;
                    $display("FAIL ack @%0t: got %b want %b", $time, rd.rd_ack_out, exp_ack);
                end
                if (sbq.size() != 0) begin
                    exp_d = sbq.pop_front();
                    if (rd.rd_ack_out === 1'b1) begin
                        compared++;
                        if (rd.rd_data_out !== exp_d) begin
                            mismatched++;
                            $display("FAIL rd_data @%0t: got %h want %h", $time, rd.rd_data_out, exp_d);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic req, input logic [1:0] addr, input logic se,
                        input logic [15:0] a, input logic [NDIN-1:0] d);
        rd.rd_req_in  = req;
        rd.rd_addr_in = addr;
        sample_en_in  = se;
        ain_in        = a;
        din_in        = d;
        @(negedge clk_in);
    endtask

    task automatic idle(input int n, input logic [NDIN-1:0] d);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 1'b0, 16'h0000, d);
    endtask

    task automatic rdreg(input logic [1:0] addr, input logic [NDIN-1:0] d);
        tick(1'b1, addr, 1'b0, 16'h0000, d);
    endtask

    initial begin
        int hold[NDIN];
        logic [NDIN-1:0] dr;
        rst_in        = 1'b0;
        din_in        = {NDIN{1'b0}};
        ain_in        = 16'h0000;
        sample_en_in  = 1'b0;
        rd.rd_req_in  = 1'b0;
        rd.rd_addr_in = 2'd0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;

        // reset values, back-to-back reads
        for (int a = 0; a < 4; a++) rdreg(2'(a), 4'b0000);
        idle(2, 4'b0000);

        // steady high on pin 0, edge clear-on-read
        idle(8, 4'b0001);
        rdreg(2'd1, 4'b0001);
        rdreg(2'd1, 4'b0001);
        rdreg(2'd0, 4'b0001);

        // short glitch rejected, long pulse accepted on pin 1
        idle(3, 4'b0011);
        idle(10, 4'b0001);
        rdreg(2'd1, 4'b0001);
        rdreg(2'd0, 4'b0001);
        idle(6, 4'b0011);
        idle(10, 4'b0001);
        rdreg(2'd1, 4'b0001);
        rdreg(2'd0, 4'b0001);

        // analog window
        tick(1'b0, 2'd0, 1'b1, 16'hBFFF, 4'b0001);
        rdreg(2'd2, 4'b0001);
        rdreg(2'd3, 4'b0001);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 1'b1, 16'hBFFF, 4'b0001);
        rdreg(2'd2, 4'b0001);
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 1'b1, 16'h0000, 4'b0001);
        rdreg(2'd2, 4'b0001);
        // strobe and read on the same edge
        tick(1'b1, 2'd3, 1'b1, 16'h1234, 4'b0001);
        rdreg(2'd3, 4'b0001);

        // read of address 1 on the very edge stable[0] rises
        idle(10, 4'b0000);
        rdreg(2'd1, 4'b0000);
        tick(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0001);
        idle(4, 4'b0001);
        rdreg(2'd1, 4'b0001);
        rdreg(2'd1, 4'b0001);
        rdreg(2'd0, 4'b0001);

        // reset mid-debounce with the pin held high
        idle(10, 4'b0000);
        rdreg(2'd1, 4'b0000);
        idle(3, 4'b0001);
        rst_in = 1'b0;
        idle(2, 4'b0001);
        rst_in = 1'b1;
        rdreg(2'd0, 4'b0001);
        for (int i = 0; i < D + 3; i++) rdreg(2'd0, 4'b0001);
        rdreg(2'd1, 4'b0001);

        // randomised traffic
        dr = 4'b0001;
        for (int i = 0; i < NDIN; i++) hold[i] = 1;
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] a;
            for (int i = 0; i < NDIN; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    dr[i]   = ~dr[i];
                    hold[i] = int'($urandom_range(1, 9));
                end
            end
            case ($urandom_range(0, 3))
                0:       a = 16'hFFFF;
                1:       a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), a, dr);
        end

        idle(3, dr);
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL pending_acks: got %0d outstanding want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
